// File: rtl/button_pkg.sv
// Shared types and default timing constants for the button event decoder.
// Pure declarations: no latency, no flow control.
package button_pkg;

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    PRESSED,
    LONG
  } btn_state_t;

  localparam int LONG_CYCLES_DEF   = 50_000_000;
  localparam int REPEAT_CYCLES_DEF = 10_000_000;
  localparam int CNT_W_DEF         = 26;

endpackage

// File: rtl/button_event_decoder_hold_timer.sv
// Hold counter with synchronous clear/enable and an equality compare against a caller-chosen limit.
// at_limit reflects the current count combinationally; the count updates one edge after clr/en; no backpressure.
module hold_timer
  import button_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Equality is enough: the FSM clears the count on the same edge it hits the limit.
  assign at_limit = (cnt == limit);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long/repeat strobes plus held levels.
// All outputs registered, 1 cycle from the sampling edge; no backpressure, strobes are fire-and-forget.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic button_in,
  output logic press_out,
  output logic release_out,
  output logic long_out,
  output logic repeat_out,
  output logic held_out,
  output logic long_held_out
);

  localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       state_q, state_d;
  logic             tmr_clr, tmr_en, at_limit;
  logic [CNT_W-1:0] limit;
  logic             press_d, release_d, long_d, repeat_d;

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .limit    (limit),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b1;
    tmr_en    = 1'b0;
    limit     = (state_q == LONG) ? REPEAT_LIM : LONG_LIM;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      // A button still held when reset lifts must be released before it can count as a press.
      WAIT_REL: begin
        if (!button_in) state_d = IDLE;
      end
      IDLE: begin
        if (button_in) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (!button_in) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (at_limit) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end
      LONG: begin
        if (!button_in) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (at_limit) begin
          repeat_d = 1'b1;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end
      default: state_d = WAIT_REL;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= WAIT_REL;
      press_out     <= 1'b0;
      release_out   <= 1'b0;
      long_out      <= 1'b0;
      repeat_out    <= 1'b0;
      held_out      <= 1'b0;
      long_held_out <= 1'b0;
    end else begin
      state_q       <= state_d;
      press_out     <= press_d;
      release_out   <= release_d;
      long_out      <= long_d;
      repeat_out    <= repeat_d;
      held_out      <= (state_d == PRESSED) || (state_d == LONG);
      long_held_out <= (state_d == LONG);
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG=8, REPEAT=4, CNT_W=4.
// Output vector order: {press, release, long, repeat, held, long_held}.
module tb_button_event_decoder;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic button_in = 1'b0;
  logic press_out, release_out, long_out, repeat_out, held_out, long_held_out;
  logic [5:0] obs;
  int checks = 0;
  int passed = 0;

  button_event_decoder #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .button_in     (button_in),
    .press_out     (press_out),
    .release_out   (release_out),
    .long_out      (long_out),
    .repeat_out    (repeat_out),
    .held_out      (held_out),
    .long_held_out (long_held_out)
  );

  always #5 clk_in = ~clk_in;

  assign obs = {press_out, release_out, long_out, repeat_out, held_out, long_held_out};

  // Strobe exclusivity watched on every cycle of every scenario.
  always @(negedge clk_in) begin
    checks++;
    if ($countones({press_out, release_out, long_out, repeat_out}) > 1)
      $display("FAIL onehot t=%0t: strobes=%b required at most one high", $time,
               {press_out, release_out, long_out, repeat_out});
    else
      passed++;
  end

  task automatic tick(input logic b);
    button_in = b;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in  = 1'b0;
    button_in = 1'b0;
    #12;
    checks++;
    if (obs !== 6'b000000) $display("FAIL reset_hold: got %b required %b", obs, 6'b000000);
    else passed++;
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0);
      checks++;
      if (obs !== 6'b000000) $display("FAIL reset_idle step %0d: got %b required %b", i, obs, 6'b000000);
      else passed++;
    end
  endtask

  task automatic test_short_press();
    logic [5:0] exp_tab [5];
    logic       btn_tab [5];
    exp_tab = '{6'b100010, 6'b000010, 6'b000010, 6'b010000, 6'b000000};
    btn_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick(btn_tab[i]);
      checks++;
      if (obs !== exp_tab[i]) $display("FAIL short_press step %0d: got %b required %b", i, obs, exp_tab[i]);
      else passed++;
    end
  endtask

  task automatic test_long_repeat();
    logic [5:0] exp;
    for (int i = 0; i <= 22; i++) begin
      tick(i <= 20);
      if (i == 0)                exp = 6'b100010;
      else if (i < 8)            exp = 6'b000010;
      else if (i == 8)           exp = 6'b001011;
      else if (i == 21)          exp = 6'b010000;
      else if (i == 22)          exp = 6'b000000;
      else if ((i - 8) % 4 == 0) exp = 6'b000111;
      else                       exp = 6'b000011;
      checks++;
      if (obs !== exp) $display("FAIL long_repeat edge k+%0d: got %b required %b", i, obs, exp);
      else passed++;
    end
  endtask

  task automatic test_release_at_long();
    logic [5:0] exp;
    for (int i = 0; i <= 9; i++) begin
      tick(i <= 7);
      if (i == 0)      exp = 6'b100010;
      else if (i < 8)  exp = 6'b000010;
      else if (i == 8) exp = 6'b010000;
      else             exp = 6'b000000;
      checks++;
      if (obs !== exp) $display("FAIL release_at_long edge k+%0d: got %b required %b", i, obs, exp);
      else passed++;
    end
    tick(1'b1);
    checks++;
    if (obs !== 6'b100010) $display("FAIL release_at_long_repress: got %b required %b", obs, 6'b100010);
    else passed++;
    tick(1'b0);
    tick(1'b0);
  endtask

  task automatic test_pulse();
    tick(1'b1);
    checks++;
    if (obs !== 6'b100010) $display("FAIL pulse_press: got %b required %b", obs, 6'b100010);
    else passed++;
    tick(1'b0);
    checks++;
    if (obs !== 6'b010000) $display("FAIL pulse_release: got %b required %b", obs, 6'b010000);
    else passed++;
    tick(1'b0);
    checks++;
    if (obs !== 6'b000000) $display("FAIL pulse_quiet: got %b required %b", obs, 6'b000000);
    else passed++;
  endtask

  task automatic test_reset_held();
    rst_n_in  = 1'b0;
    button_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      checks++;
      if (obs !== 6'b000000) $display("FAIL reset_held step %0d: got %b required %b", i, obs, 6'b000000);
      else passed++;
    end
    tick(1'b0);
    checks++;
    if (obs !== 6'b000000) $display("FAIL reset_held_drop: got %b required %b", obs, 6'b000000);
    else passed++;
    tick(1'b1);
    checks++;
    if (obs !== 6'b100010) $display("FAIL reset_held_press: got %b required %b", obs, 6'b100010);
    else passed++;
    tick(1'b0);
    checks++;
    if (obs !== 6'b010000) $display("FAIL reset_held_release: got %b required %b", obs, 6'b010000);
    else passed++;
  endtask

  task automatic test_async_reset();
    tick(1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1);
    checks++;
    if (obs !== 6'b000011) $display("FAIL async_in_long: got %b required %b", obs, 6'b000011);
    else passed++;
    #3;
    rst_n_in = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b000000) $display("FAIL async_clear: got %b required %b", obs, 6'b000000);
    else passed++;
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      checks++;
      if (obs !== 6'b000000) $display("FAIL async_post_held step %0d: got %b required %b", i, obs, 6'b000000);
      else passed++;
    end
    tick(1'b0);
    checks++;
    if (obs !== 6'b000000) $display("FAIL async_no_release: got %b required %b", obs, 6'b000000);
    else passed++;
    tick(1'b1);
    checks++;
    if (obs !== 6'b100010) $display("FAIL async_repress: got %b required %b", obs, 6'b100010);
    else passed++;
    tick(1'b0);
    checks++;
    if (obs !== 6'b010000) $display("FAIL async_rerelease: got %b required %b", obs, 6'b010000);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_at_long();
    test_pulse();
    test_reset_held();
    test_async_reset();
    tick(1'b0);
    tick(1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the clean, synchronous button level produced by the debouncer and turns it into discrete user-interface events. It emits one-cycle press and release strobes, a one-cycle long-press strobe after a programmable hold time, and periodic auto-repeat strobes while the button stays held. It sits between the debouncer and the game/control FSMs, so downstream logic never edge-detects or times buttons itself.

## Interface
Parameters:
- LONG_CYCLES, default 50_000_000: hold time before long press (0.5 s at 100 MHz); must be ≥ 2.
- REPEAT_CYCLES, default 10_000_000: auto-repeat period after a long press; must be ≥ 2.
- CNT_W, default 26: hold-counter width; must satisfy 2^CNT_W ≥ max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk_in, input, 1: system clock; single clock domain.
- rst_n_in, input, 1: reset, asynchronous, active-low.
- button_in, input, 1: debounced level, already synchronous to clk_in; 1 means pressed.
- press_out, output, 1: one-cycle strobe on an accepted press.
- release_out, output, 1: one-cycle strobe on release.
- long_out, output, 1: one-cycle strobe when the hold reaches LONG_CYCLES.
- repeat_out, output, 1: one-cycle strobe every REPEAT_CYCLES while in long hold.
- held_out, output, 1: level, high while in PRESSED or LONG.
- long_held_out, output, 1: level, high while in LONG.

## Operation
- The FSM has four states: WAIT_REL, IDLE, PRESSED, LONG. A single hold counter `cnt` is CNT_W bits wide.
- Reset forces the state to WAIT_REL, `cnt` to 0, and every output to 0.
- WAIT_REL: stay here while button_in = 1, with no strobes. Go to IDLE on the first edge that samples 0. A button held through reset is never reported as a press.
- IDLE: on button_in = 1, go to PRESSED, set `cnt` to 0, and assert press_out.
- PRESSED:
  - If button_in = 0: go to IDLE and assert release_out.
  - Else if `cnt` = LONG_CYCLES−1: go to LONG, set `cnt` to 0, and assert long_out.
  - Else: `cnt` increments by 1.
- LONG:
  - If button_in = 0: go to IDLE and assert release_out.
  - Else if `cnt` = REPEAT_CYCLES−1: set `cnt` to 0 and assert repeat_out.
  - Else: `cnt` increments by 1.
- Release has priority over the long and repeat thresholds. If both occur on the same edge, only release_out fires.
- The strobes are mutually exclusive: at most one of press/release/long/repeat is high in any cycle.
- `cnt` never wraps beyond its threshold; comparisons use equality, which is valid under the CNT_W constraint.
- A 1-cycle press (button_in high for one sampled edge) produces press_out and then release_out on consecutive cycles.

## Timing
- All outputs are registered, with no combinational path from button_in.
- Let edge k be the first edge sampling button_in = 1 in IDLE. Then:
  - press_out is high for the cycle after edge k.
  - long_out is high after edge k+LONG_CYCLES.
  - repeat_out is high after edge k+LONG_CYCLES+m·REPEAT_CYCLES, for m = 1, 2, …
- Let edge j be the first edge sampling 0 while held. Then release_out is high after edge j, and held_out/long_held_out drop after edge j.
- Latency from button_in to a press or release strobe is 1 cycle.
- A reset assertion mid-hold clears outputs immediately (asynchronously). The next press is recognised only after a sampled release.

## Structure
- Package `button_pkg` holds:
  - the state enum (WAIT_REL, IDLE, PRESSED, LONG);
  - default LONG_CYCLES, REPEAT_CYCLES and CNT_W constants.
- One sub-module is natural: `hold_timer`, the CNT_W-bit counter with clear, enable and a compare-to-limit output. The FSM selects the limit (LONG_CYCLES−1 or REPEAT_CYCLES−1) per state.
- The top level instantiates the FSM logic plus one `hold_timer`.

## Test plan
All scenarios use the bench overrides LONG_CYCLES = 8, REPEAT_CYCLES = 4, CNT_W = 4.
- Reset with button_in = 0, then hold high for 3 cycles and drop. Expect press_out after edge k and release_out after edge k+3; long_out stays 0 and held_out is high for exactly 3 cycles.
- Hold from edge k for 20 cycles. Expect long_out after edge k+8 and repeat_out after edges k+12, k+16, k+20 (held ≥ 21). long_held_out rises with long_out.
- Release on edge k+8, the long-threshold edge. Expect release_out only, long_out never asserts, and the state returns to IDLE.
- Keep button_in = 1 while deasserting rst_n_in, and hold for 10 cycles. Expect no strobes. Then drop for 1 cycle and raise: press_out fires 1 cycle later.
- Assert rst_n_in low mid-LONG, asynchronously between edges. Expect all outputs 0 before the next edge and no release_out after reset.
- Apply a single-cycle pulse on button_in. Expect press_out and then release_out on consecutive cycles. Check that no two strobes are ever high together across all scenarios.
